fn_tdm_demux_2: RTL
===================

Name: fn_tdm_demux_2

Overview:
- Receive-side counterpart of the 2:1 select mux (fn_sw family).
- A transmitter interleaves channel A and channel B onto one stream, alternating the mux select; this block de-interleaves that stream back into two registered channel outputs.
- Frame alignment comes from a sync strobe that marks every channel-A word.
- Sits directly downstream of the mux in the learn/ test designs.

Parameters:
- WIDTH, 1, data word width of the stream and of each channel output.
- CNT_W, 8, width of the frame counter (optional feature only).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  interleaved stream word.
- din_valid  in  1  din is valid this cycle.
- din_sync  in  1  qualifies din as a channel-A word (frame start); ignored when din_valid=0.
- a_out  out  WIDTH  last completed channel-A word.
- b_out  out  WIDTH  last completed channel-B word.
- pair_valid  out  1  one-cycle pulse when a new A/B pair is presented.
- sync_err  out  1  sticky flag for framing violations.
- frame_cnt  out  CNT_W  completed-pair count (present only with FN_TDM_DEMUX_CNT_EN).

Behaviour:
- Reset (rst=1 at a clk edge) values: state=HUNT, a_out=0, b_out=0, pair_valid=0, sync_err=0, frame_cnt=0, internal A holding register=0.
- Reset mid-frame discards any partially received pair; no pair_valid results from it.
- All outputs are registered. Inputs are sampled only when din_valid=1; cycles with din_valid=0 leave the state unchanged (gaps are allowed).
- States and transitions:
  - HUNT: valid & sync -> capture din into A_hold, go to WAIT_B. Valid & !sync -> discard, stay in HUNT, no error.
  - WAIT_B: valid & !sync -> a_out<=A_hold, b_out<=din, pair_valid<=1 on the next edge, go to WAIT_A. Valid & sync (two A words in a row) -> sync_err<=1, A_hold<=din, stay in WAIT_B, no pair emitted.
  - WAIT_A: valid & sync -> A_hold<=din, go to WAIT_B. Valid & !sync (A slot missing) -> sync_err<=1, discard word, go to HUNT.
- Latency: pair_valid rises on the clk edge that samples the B word, i.e. a_out, b_out and pair_valid change together one cycle after the B word is presented.
- pair_valid is high for exactly one cycle per pair; back-to-back pairs are allowed when valid is continuous (one pulse every 2 cycles).
- a_out and b_out hold their values between pairs; they update only together.
- sync_err is sticky and clears only on rst.

Optional Feature:
- Macro: FN_TDM_DEMUX_CNT_EN.
- Defined: port frame_cnt exists. It increments by 1 on every pair_valid and wraps from 2^CNT_W-1 to 0 with no flag. It is not incremented on error paths.
- Undefined: port frame_cnt and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fn_tdm_pkg:
  - state encoding constants ST_HUNT=2'd0, ST_WAIT_A=2'd1, ST_WAIT_B=2'd2.
  - default WIDTH and CNT_W constants, shared with the matching mux transmitter.
- One sub-module, fn_tdm_frame_fsm: owns the state register, sync_err and the capture/emit enables.
- The top level holds the data registers and the optional counter.

Test Plan:
- Reset then stream (valid=1) A=1,sync=1 / B=0 / A=0,sync=1 / B=1 -> pair_valid pulses 1 cycle after each B; pairs (a,b)=(1,0) then (0,1); sync_err=0.
- Words with sync=0 while in HUNT (3 words), then A=1,sync=1 / B=1 -> first three ignored; single pair (1,1); no error.
- Sync on two consecutive valid words (A=0, then A=1), then B=0 -> sync_err=1 at the second A; pair emitted is (1,0).
- Insert valid=0 gaps of 1–3 cycles between A and B -> pair still correct; pair_valid only after B is sampled.
- Assert rst while in WAIT_B, then release -> all outputs 0, state HUNT; a following B word (sync=0) does not emit a pair.
- With FN_TDM_DEMUX_CNT_EN and CNT_W=2: 5 good pairs -> frame_cnt sequence 1,2,3,0,1. Without the macro: compile passes and the frame_cnt port is absent.

Source files
------------

// File: rtl/fn_tdm_pkg.sv
// fn_tdm_pkg
// Shared constants for the fn_tdm family (2:1 TDM mux transmitter and the
// matching demux receiver): frame FSM state encoding and default widths.
package fn_tdm_pkg;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_WAIT_A = 2'd1;
  localparam logic [1:0] ST_WAIT_B = 2'd2;

  localparam int FN_TDM_WIDTH = 1;
  localparam int FN_TDM_CNT_W = 8;

endpackage

// File: rtl/fn_tdm_frame_fsm.sv
// fn_tdm_frame_fsm
// Frame-alignment FSM for the TDM demux. Tracks which slot (A or B) the next
// valid word belongs to, raises the sticky framing error flag, and issues the
// capture/emit enables consumed by the data path in the top level.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   din_valid  in   stream word valid
//   din_sync   in   stream word is a channel-A word (frame start)
//   cap_a      out  load the current word into the A holding register
//   emit       out  current word is B; present the pair on the next edge
//   sync_err   out  sticky framing violation flag
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_HUNT    | no alignment yet; waiting for a sync-qualified A word
// ST_WAIT_B  | A word held; next valid non-sync word completes the pair
// ST_WAIT_A  | pair just completed; next valid word must carry sync
module fn_tdm_frame_fsm
  import fn_tdm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din_valid,
  input  logic din_sync,
  output logic cap_a,
  output logic emit,
  output logic sync_err
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       err_set;

  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    emit      = 1'b0;
    err_set   = 1'b0;
    if (din_valid) begin
      case (state)
        ST_HUNT: begin
          if (din_sync) begin
            cap_a     = 1'b1;
            state_nxt = ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (din_sync) begin
            // Two A words in a row: keep the newer one as the A candidate.
            err_set = 1'b1;
            cap_a   = 1'b1;
          end else begin
            emit      = 1'b1;
            state_nxt = ST_WAIT_A;
          end
        end
        ST_WAIT_A: begin
          if (din_sync) begin
            cap_a     = 1'b1;
            state_nxt = ST_WAIT_B;
          end else begin
            // A slot missing: alignment lost, re-acquire from scratch.
            err_set   = 1'b1;
            state_nxt = ST_HUNT;
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HUNT;
      sync_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_set) sync_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fn_tdm_demux_2.sv
// fn_tdm_demux_2
// Receive-side 1:2 TDM demultiplexer. De-interleaves an A/B alternating
// stream (A words marked by din_sync) into two registered channel outputs
// that update together, with a one-cycle pair_valid pulse per pair.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   din         in   interleaved stream word [WIDTH]
//   din_valid   in   din valid this cycle
//   din_sync    in   din is a channel-A word (ignored when din_valid=0)
//   a_out       out  last completed channel-A word [WIDTH]
//   b_out       out  last completed channel-B word [WIDTH]
//   pair_valid  out  one-cycle pulse when a new A/B pair is presented
//   sync_err    out  sticky framing violation flag
//   frame_cnt   out  completed-pair count [CNT_W], wrapping
//                    (only when FN_TDM_DEMUX_CNT_EN is defined)
//
// Build option: FN_TDM_DEMUX_CNT_EN adds the frame_cnt port and counter.
module fn_tdm_demux_2
  import fn_tdm_pkg::*;
#(
  parameter int WIDTH = FN_TDM_WIDTH,
  parameter int CNT_W = FN_TDM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             din_sync,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             pair_valid,
  output logic             sync_err
`ifdef FN_TDM_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] frame_cnt
`endif
);

  logic             cap_a;
  logic             emit;
  logic [WIDTH-1:0] a_hold;

  fn_tdm_frame_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din_sync  (din_sync),
    .cap_a     (cap_a),
    .emit      (emit),
    .sync_err  (sync_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_hold     <= '0;
      a_out      <= '0;
      b_out      <= '0;
      pair_valid <= 1'b0;
    end else begin
      pair_valid <= emit;
      if (cap_a) a_hold <= din;
      if (emit) begin
        a_out <= a_hold;
        b_out <= din;
      end
    end
  end

`ifdef FN_TDM_DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (emit) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  // CNT_W stays in the parameter list so both builds instantiate identically;
  // this empty block only anchors the otherwise unused parameter.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
